// File: rtl/mmips_defs.sv
// ---------------------------------------------------------------------------
// mmips_defs
// Shared definitions for the MMIPS memory arbiter: default widths, arbiter
// state encoding and owner encoding.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package mmips_defs;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/arb_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
// Combinational owner select for the memory arbiter.
//   Build option MEM_ARB_RR_EN:
//     defined   - round-robin on conflict (grant the side not served last)
//     undefined - fixed priority, data beats fetch; last_owner port absent
// Ports:
//   if_req      in   fetch request
//   d_req       in   data request
//   last_owner  in   owner of the previous grant (round-robin build only)
//   any_req     out  at least one request pending
//   owner       out  selected owner (meaningful only when any_req)
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module arb_pick
  import mmips_defs::*;
(
  input  logic   if_req,
  input  logic   d_req,
`ifdef MEM_ARB_RR_EN
  input  owner_t last_owner,
`endif
  output logic   any_req,
  output owner_t owner
);

  always_comb begin
    any_req = if_req | d_req;
    owner   = OWN_IF;
`ifdef MEM_ARB_RR_EN
    if (if_req && d_req) begin
      // Conflict: the side that was not served last wins.
      owner = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
    end else if (d_req) begin
      owner = OWN_D;
    end
`else
    if (d_req) begin
      owner = OWN_D;
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares the single MMIPS memory port between instruction fetch and
// load/store. One memory transaction at a time; the winner's request fields
// are latched at grant, memory is held until mem_ack, and read data is
// returned with a one-cycle done pulse. All outputs are registered.
//   Build option MEM_ARB_RR_EN: round-robin arbitration when defined,
//   fixed data-over-fetch priority otherwise.
// Ports:
//   clk, rst                      clock, async active-high reset
//   if_req/if_addr                fetch request (held until if_done)
//   if_rdata/if_done              fetch read data and completion pulse
//   d_req/d_we/d_addr/d_wdata     load/store request (held until d_done)
//   d_rdata/d_done                load data and completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata                     memory request (held until mem_ack)
//   mem_rdata/mem_ack             memory read data and completion
//   busy                          arbiter not in IDLE
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import mmips_defs::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  state_t state;
  state_t next_state;
  owner_t cur_owner;
  owner_t pick_owner;
  logic   pick_any;
  logic   grant;
  logic   ack_busy;

`ifdef MEM_ARB_RR_EN
  owner_t last_owner;
`endif

  arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
`ifdef MEM_ARB_RR_EN
    .last_owner (last_owner),
`endif
    .any_req    (pick_any),
    .owner      (pick_owner)
  );

  // Next-state logic. Requests are only looked at in IDLE, and mem_ack only
  // in BUSY, so acks arriving in IDLE/RESP fall through harmlessly.
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    ack_busy   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          grant      = 1'b1;
          next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          ack_busy   = 1'b1;
          next_state = ST_RESP;
        end
      end
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // State register plus registered outputs, derived from the next state so
  // mem_req/busy line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_owner <= OWN_IF;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
    end else begin
      state   <= next_state;
      busy    <= (next_state != ST_IDLE);
      mem_req <= (next_state == ST_BUSY);
      if_done <= 1'b0;
      d_done  <= 1'b0;

      // Latch the winner so requester changes during BUSY do not reach memory.
      if (grant) begin
        cur_owner <= pick_owner;
        if (pick_owner == OWN_D) begin
          mem_addr  <= d_addr;
          mem_we    <= d_we;
          mem_wdata <= d_wdata;
        end else begin
          mem_addr  <= if_addr;
          mem_we    <= 1'b0;
          mem_wdata <= '0;
        end
      end

      if (ack_busy) begin
        if (cur_owner == OWN_IF) begin
          if_rdata <= mem_rdata;
          if_done  <= 1'b1;
        end else begin
          d_done <= 1'b1;
          // A store leaves the previous load data in place.
          if (!mem_we) begin
            d_rdata <= mem_rdata;
          end
        end
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= OWN_IF;
    end else if (grant) begin
      last_owner <= pick_owner;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single unified memory port of the MMIPS core between the instruction-fetch requester and the load/store requester. Sits between the `CPU` datapath and the memory model: fetch and data units issue held-level requests; the arbiter serialises them onto one memory transaction at a time and returns read data with a one-cycle done pulse. Memory latency is variable; the arbiter waits on `mem_ack`.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `if_req`  in  1  fetch request, held until `if_done`
- `if_addr`  in  ADDR_W  fetch address, stable while `if_req`
- `if_rdata`  out  DATA_W  fetched word, valid with `if_done`
- `if_done`  out  1  one-cycle completion pulse to fetch
- `d_req`  in  1  data request, held until `d_done`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_rdata`  out  DATA_W  load data, valid with `d_done`
- `d_done`  out  1  one-cycle completion pulse to data unit
- `mem_req`  out  1  memory request, held until `mem_ack`
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_ack`
- `mem_ack`  in  1  memory completion, one cycle
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if any request is high, select owner, latch owner's address/we/wdata into registers, go to BUSY. Fetch requests always use `mem_we`=0.
- BUSY: `mem_req`=1 with latched fields. On `mem_ack`: capture `mem_rdata` into owner's rdata register, go to RESP. Requester input changes during BUSY are ignored (latched copy drives memory).
- RESP: owner's done = 1 for exactly this cycle; `mem_req`=0; go to IDLE. Requests are not sampled in RESP.
- `mem_ack` in IDLE or RESP: ignored.
- Selection, fixed mode: data beats fetch when both high.
- Store completion: `d_done` pulses; `d_rdata` holds previous value.
- rdata registers hold until overwritten by next owner's transaction.
- Requester keeping req high past the cycle after done issues a new request.

## Timing
- Reset (async, immediate): state IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `if_done`=0, `d_done`=0, `if_rdata`=0, `d_rdata`=0, `busy`=0, last-owner = fetch.
- Req seen in IDLE at edge N → `mem_req`=1 from N+1.
- `mem_ack` at edge M → done pulse and `mem_req`=0 in cycle M+1; IDLE at M+2.
- Zero-wait memory (ack in first BUSY cycle): 3 cycles request-to-IDLE; back-to-back grants every 3 cycles.
- Reset mid-BUSY: `mem_req` drops asynchronously; no done pulse; outstanding transaction abandoned; memory must tolerate it.
- All outputs registered; no combinational path input→output.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. On conflict in IDLE, grant the requester not served last; last-owner register updates at each grant. Single requester always granted.
- Undefined: fixed data-over-fetch priority; last-owner register not implemented.

## Structure
- Shared package `mmips_defs`: state encoding (IDLE/BUSY/RESP), owner encoding (OWN_IF/OWN_D), default widths.
- One sub-module `arb_pick`: combinational owner select from `if_req`, `d_req`, last-owner; contains the `MEM_ARB_RR_EN` conditional.

## Test plan
- Reset: assert `rst` mid-BUSY → `mem_req`, `busy`, dones go 0 same cycle; no done after release.
- Single fetch `if_addr`=0x40, memory acks 2 cycles later with 0x8C010004 → `if_rdata`=0x8C010004, one `if_done` pulse, `mem_we`=0 throughout.
- Store `d_addr`=0x100, `d_wdata`=0xDEADBEEF, zero-wait ack → `mem_we`=1, `mem_addr`=0x100, `d_done` pulse 1 cycle after ack, `d_rdata` unchanged.
- Simultaneous `if_req`/`d_req` held for two transactions: fixed build → data then fetch; RR build after a fetch grant → data then fetch, after a data grant → fetch then data.
- Change `d_addr` from 0x100 to 0x200 while BUSY → `mem_addr` stays 0x100.
- Spurious `mem_ack` in IDLE → no done pulse, no state change.
